data_mem_unit: RTL and testbench
================================

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning address width; memory depth = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 16, meaning word width.
REQ-003 SHALL have port clock  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_rd  input  1  read request strobe from control_unit.
REQ-006 SHALL have port mem_wr  input  1  write request strobe from control_unit.
REQ-007 SHALL have port addr  input  ADDR_W  word address, sampled with the request.
REQ-008 SHALL have port wdata  input  DATA_W  write data, sampled with mem_wr.
REQ-009 SHALL have port rdata  output  DATA_W  registered read data.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse for the accepted request.
REQ-011 SHALL have port mem_busy  output  1  high whenever the FSM is not IDLE.
REQ-012 SHALL have port mem_err  output  1  one-cycle pulse when a request is dropped.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, READ, RDONE; all are registered.
REQ-014 In IDLE, on a rising edge k with mem_wr=1, SHALL capture addr/wdata and go to WRITE.
REQ-015 In IDLE with mem_wr=0 and mem_rd=1 at edge k, SHALL capture addr and go to READ.
REQ-016 If mem_rd and mem_wr are both 1 in IDLE, SHALL accept the write only, with no mem_err.
REQ-017 WRITE SHALL commit the captured word to the captured address at edge k+1, go to IDLE, and hold mem_ready=1 from edge k+1 to edge k+2.
REQ-018 READ SHALL load the array word at the captured address into rdata at edge k+1 and go to RDONE.
REQ-019 RDONE SHALL hold mem_ready=1 from edge k+2 to edge k+3 with rdata valid, then return to IDLE.
REQ-020 Read latency SHALL be 2 cycles and write latency 1 cycle from the sampling edge to mem_ready.
REQ-021 rdata SHALL hold its last read value until the next read completes; writes SHALL NOT alter rdata, even to the same address.
REQ-022 A request (mem_rd or mem_wr) sampled while not IDLE SHALL be dropped, with mem_err=1 for the following cycle and no state or array change.
REQ-023 A new request sampled in IDLE in the same cycle that mem_ready is high SHALL be accepted, allowing back-to-back operation.
REQ-024 Addresses SHALL cover 0 to 2**ADDR_W-1 with no wrap or aliasing; the full ADDR_W field is decoded.
REQ-025 mem_busy SHALL be combinationally derived from state (state != IDLE).

Reset
REQ-026 When reset=0, the block SHALL asynchronously force state=IDLE, rdata=0, mem_ready=0, mem_err=0 and mem_busy=0.
REQ-027 Reset SHALL clear captured address/data registers to 0; array contents SHALL NOT be reset.
REQ-028 Reset asserted in WRITE before edge k+1 SHALL discard the pending write, leaving the array unchanged.
REQ-029 Reset asserted in READ/RDONE SHALL abort the read with no mem_ready pulse.
REQ-030 After reset deasserts, the first request SHALL be accepted at the first rising edge at which it is sampled.

Verification
REQ-031 Write 0xA5A5 to addr 0x03, then read addr 0x03 -> mem_ready 1 cycle after write, mem_ready 2 cycles after read, rdata=0xA5A5.
REQ-032 mem_rd=1 and mem_wr=1 with addr 0x10 and wdata 0x1234 -> write taken, no mem_err; a subsequent read of 0x10 returns 0x1234.
REQ-033 Read issued, then mem_wr pulsed at edge k+1 -> mem_err=1 for one cycle, write dropped, rdata correct, array unchanged.
REQ-034 Write 0xBEEF to 0x00 and 0xCAFE to 0xFF back-to-back, then read both -> 0xBEEF and 0xCAFE respectively; no aliasing.
REQ-035 Write 0x0F0F to 0x20, then write 0xFFFF to 0x20 with reset=0 asserted before edge k+1 -> outputs 0 immediately; after release, a read of 0x20 returns 0x0F0F.

Source files
------------

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_unit
// Description : Single-port word-addressed data memory with a request FSM.
//               Accepts one request at a time; write/read completion is
//               signalled by a one-cycle mem_ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int c_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RDONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];

    assign mem_busy = (r_state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A simultaneous read+write request is served as a write.
                    if (mem_wr) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_state <= WRITE;
                    end else if (mem_rd) begin
                        r_addr  <= addr;
                        r_state <= READ;
                    end
                end
                WRITE: begin
                    mem_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                READ: begin
                    rdata   <= r_mem[r_addr];
                    r_state <= RDONE;
                end
                RDONE: begin
                    mem_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if ((r_state != IDLE) && (mem_rd || mem_wr))
                mem_err <= 1'b1;
        end
    end

    // Reset forces r_state to IDLE asynchronously, so a pending write is discarded.
    always_ff @(posedge clock) begin
        if (r_state == WRITE)
            r_mem[r_addr] <= r_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_unit
// Description : Randomized self-checking bench for data_mem_unit against a
//               transaction-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_unit;

    logic        clock;
    logic        reset;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        mem_ready;
    logic        mem_busy;
    logic        mem_err;

    int          n_checks;
    int          n_errors;
    logic [15:0] model_mem [256];
    logic [15:0] exp_rdata;

    data_mem_unit #(.ADDR_W(8), .DATA_W(16)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mem_ready (mem_ready),
        .mem_busy  (mem_busy),
        .mem_err   (mem_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drops a random request onto the bus; used to probe the busy-window.
    task automatic intrude();
        mem_wr = 1'($urandom_range(0, 1));
        mem_rd = ~mem_wr;
        addr   = 8'($urandom);
        wdata  = 16'($urandom);
    endtask

    // All transaction tasks start and end 1 time unit after a rising edge.
    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input bit both, input bit intr);
        mem_wr = 1'b1;
        mem_rd = both;
        addr   = a;
        wdata  = d;
        @(posedge clock); #1;
        mem_wr = 1'b0;
        mem_rd = 1'b0;
        check_value("wr_busy", mem_busy, 1);
        check_value("wr_ready_early", mem_ready, 0);
        check_value("wr_err_accept", mem_err, 0);
        if (intr) intrude();
        @(posedge clock); #1;
        mem_wr = 1'b0;
        mem_rd = 1'b0;
        model_mem[a] = d;
        check_value("wr_ready", mem_ready, 1);
        check_value("wr_idle", mem_busy, 0);
        check_value("wr_err_drop", mem_err, 32'(intr));
        check_value("wr_rdata_hold", rdata, exp_rdata);
    endtask

    task automatic do_read(input logic [7:0] a, input bit intr);
        mem_rd = 1'b1;
        addr   = a;
        @(posedge clock); #1;
        mem_rd = 1'b0;
        check_value("rd_busy", mem_busy, 1);
        check_value("rd_ready_early", mem_ready, 0);
        check_value("rd_err_accept", mem_err, 0);
        check_value("rd_rdata_old", rdata, exp_rdata);
        exp_rdata = model_mem[a];
        if (intr) intrude();
        @(posedge clock); #1;
        mem_wr = 1'b0;
        mem_rd = 1'b0;
        check_value("rd_busy2", mem_busy, 1);
        check_value("rd_ready_mid", mem_ready, 0);
        check_value("rd_err_drop", mem_err, 32'(intr));
        check_value("rd_rdata_load", rdata, exp_rdata);
        @(posedge clock); #1;
        check_value("rd_ready", mem_ready, 1);
        check_value("rd_idle", mem_busy, 0);
        check_value("rd_err_clear", mem_err, 0);
        check_value("rd_rdata", rdata, exp_rdata);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_rdata"}, rdata, 0);
        check_value({tag, "_ready"}, mem_ready, 0);
        check_value({tag, "_busy"}, mem_busy, 0);
        check_value({tag, "_err"}, mem_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_rdata = '0;
        reset     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        addr      = '0;
        wdata     = '0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;

        // Write then read back; first request right after reset release.
        do_write(8'h03, 16'hA5A5, 1'b0, 1'b0);
        do_read(8'h03, 1'b0);

        // Give every word a known value so the model covers all reads.
        for (int i = 0; i < 256; i++) begin
            if (i != 3) do_write(8'(i), 16'($urandom), 1'b0, 1'b0);
        end

        // Simultaneous read and write: the write wins.
        do_write(8'h10, 16'h1234, 1'b1, 1'b0);
        do_read(8'h10, 1'b0);

        // Write pulsed during a read is dropped with an error.
        mem_rd = 1'b1;
        addr   = 8'h10;
        @(posedge clock); #1;
        mem_rd = 1'b0;
        mem_wr = 1'b1;
        addr   = 8'h11;
        wdata  = ~model_mem[8'h11];
        exp_rdata = model_mem[8'h10];
        @(posedge clock); #1;
        mem_wr = 1'b0;
        check_value("conf_err", mem_err, 1);
        check_value("conf_rdata", rdata, exp_rdata);
        @(posedge clock); #1;
        check_value("conf_err_clear", mem_err, 0);
        check_value("conf_ready", mem_ready, 1);
        do_read(8'h11, 1'b0);

        // Address extremes back-to-back.
        do_write(8'h00, 16'hBEEF, 1'b0, 1'b0);
        do_write(8'hFF, 16'hCAFE, 1'b0, 1'b0);
        do_read(8'h00, 1'b0);
        do_read(8'hFF, 1'b0);

        // Reset while a write is pending discards it.
        do_write(8'h20, 16'h0F0F, 1'b0, 1'b0);
        mem_wr = 1'b1;
        addr   = 8'h20;
        wdata  = 16'hFFFF;
        @(posedge clock); #1;
        mem_wr = 1'b0;
        check_value("rstw_busy", mem_busy, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("rstw");
        exp_rdata = '0;
        @(posedge clock); #1;
        check_reset_outputs("rstw_hold");
        reset = 1'b1;
        do_read(8'h20, 1'b0);

        // Reset during READ and during RDONE aborts with no ready pulse.
        for (int ph = 0; ph < 2; ph++) begin
            mem_rd = 1'b1;
            addr   = 8'($urandom);
            @(posedge clock); #1;
            mem_rd = 1'b0;
            if (ph == 1) begin
                @(posedge clock); #1;
            end
            reset = 1'b0;
            #1;
            check_reset_outputs("rstr");
            exp_rdata = '0;
            @(posedge clock); #1;
            reset = 1'b1;
            @(posedge clock); #1;
            check_reset_outputs("rstr_after");
        end

        // Randomized mix of operations, including dropped requests.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: do_write(8'($urandom), 16'($urandom), 1'b0, 1'b0);
                1: do_write(8'($urandom), 16'($urandom), 1'b1, 1'b0);
                2: do_write(8'($urandom), 16'($urandom), 1'b0, 1'b1);
                3: do_read(8'($urandom), 1'b0);
                default: do_read(8'($urandom), 1'b1);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
